acondicionador_botones: RTL and testbench
=========================================

Name: acondicionador_botones

Overview:
- Conditions the raw push-button inputs (Up, Down, Tono, color, Lp) before they reach the chroma control stage of the VGA path.
- Per button, it synchronises the input to Clk, debounces it with a 4-state FSM, and produces a clean level plus a one-cycle press pulse.
- The chroma controller consumes the pulses, so one physical press changes tone or colour exactly once.
- Optional auto-repeat lets held Up/Down buttons step continuously.

Parameters:
- N_BOTONES, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, cycles an input must hold a new level before it is accepted (10 ms at 25 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 24, width of each per-channel counter.
- REPEAT_DELAY, 12500000, cycles held before the first auto-repeat pulse (only with AUTOREPEAT_EN).
- REPEAT_RATE, 2500000, cycles between subsequent auto-repeat pulses (only with AUTOREPEAT_EN).
- REPEAT_MASK, 5'b00011, channels eligible for auto-repeat; bit0=Up, bit1=Down.

Ports:
- Clk  input  1  system pixel clock.
- reset  input  1  asynchronous, active-low reset.
- btn_in  input  N_BOTONES  raw asynchronous button levels, active-high.
- btn_level  output  N_BOTONES  debounced button level.
- btn_pulse  output  N_BOTONES  one-cycle strobe per accepted press and per auto-repeat event.

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchroniser flops, counters, btn_level and btn_pulse go to 0;
  - every FSM goes to ESTABLE_BAJO.
- Synchroniser: 2-flop chain per channel (s1, s2). The FSM sees only s2.
- Per-channel FSM states: ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO.
  - ESTABLE_BAJO: if s2=1, go to VALIDANDO_ALTO and set cnt=0.
  - VALIDANDO_ALTO:
    - s2=0 returns to ESTABLE_BAJO with no output change;
    - s2=1 and cnt<DEBOUNCE_CYCLES-1 increments cnt;
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 goes to ESTABLE_ALTO, sets btn_level=1 and btn_pulse=1 for exactly one cycle.
  - ESTABLE_ALTO: if s2=0, go to VALIDANDO_BAJO and set cnt=0.
  - VALIDANDO_BAJO: mirror of VALIDANDO_ALTO. On acceptance go to ESTABLE_BAJO with btn_level=0. No pulse on release.
- Latency:
  - raw rise settled before edge 1 gives btn_level/btn_pulse high after edge DEBOUNCE_CYCLES+3;
  - the same latency applies to release on btn_level.
- Registered outputs: btn_pulse is registered and never wider than one cycle, except with auto-repeat (below).
- Glitches: a glitch shorter than DEBOUNCE_CYCLES cycles (as seen at s2) produces no level change and no pulse, and the counter restarts on the next edge.
- Channel independence: channels are fully independent. Simultaneous presses yield simultaneous pulses in the same cycle.
- Counter width: cnt saturates and never wraps; only values up to DEBOUNCE_CYCLES-1 are reachable.
- Reset mid-validation: the channel returns to ESTABLE_BAJO and no pulse is emitted.
- Button held through reset release: treated as a new press, so a pulse fires DEBOUNCE_CYCLES+3 cycles after reset deasserts.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - each channel with its REPEAT_MASK bit set has a repeat counter rcnt (CNT_W bits), cleared on entry to ESTABLE_ALTO;
  - while in ESTABLE_ALTO, the first repeat pulse fires REPEAT_DELAY cycles after the press pulse;
  - further pulses fire every REPEAT_RATE cycles;
  - rcnt reloads on each repeat pulse;
  - leaving ESTABLE_ALTO (including VALIDANDO_BAJO) stops repeating immediately and clears rcnt;
  - a return from VALIDANDO_BAJO to ESTABLE_ALTO restarts the REPEAT_DELAY phase.
- Undefined: no repeat logic is synthesised; exactly one pulse per accepted press on every channel.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset: reset=0 with btn_in=5'b11111 -> btn_level=0, btn_pulse=0. After release, each channel pulses once at cycle 7 and btn_level=5'b11111.
- Clean press on bit0 held 20 cycles -> btn_pulse[0] high for exactly one cycle, 7 edges after the rise; btn_level[0] high until 7 edges after the fall; no pulse on release.
- Bounce: bit2 toggles 1,0,1,0 at 1-cycle intervals, then holds 1 -> no pulse during bounce; a single pulse 7 edges after the final rise.
- Glitch of 3 cycles on bit4 -> btn_level[4] and btn_pulse[4] stay 0 throughout.
- reset asserted 2 cycles into VALIDANDO_ALTO on bit1 with btn_in released during reset -> no pulse; FSM in ESTABLE_BAJO.
- AUTOREPEAT_EN defined, bit1 held 30 cycles -> pulses at press cycle P, P+10, P+13, P+16, ...; bit3 (mask 0) held 30 cycles -> a single pulse only.

Source files
------------

// File: rtl/acondicionador_botones.sv
// acondicionador_botones: per-button 2-flop sync, 4-state debounce FSM, clean level and press pulse.
// Optional AUTOREPEAT_EN adds hold-to-repeat pulses on REPEAT_MASK channels.
module acondicionador_botones #(
  parameter int N_BOTONES = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 24,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE = 2500000,
  parameter logic [N_BOTONES-1:0] REPEAT_MASK = 5'b00011
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] btn_in,
  output logic [N_BOTONES-1:0] btn_level,
  output logic [N_BOTONES-1:0] btn_pulse
);
  localparam logic [1:0] ESTABLE_BAJO   = 2'd0;
  localparam logic [1:0] VALIDANDO_ALTO = 2'd1;
  localparam logic [1:0] ESTABLE_ALTO   = 2'd2;
  localparam logic [1:0] VALIDANDO_BAJO = 2'd3;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_BOTONES-1:0] r_s1, r_s2;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  genvar i;
  for (i = 0; i < N_BOTONES; i++) begin : g_canal
    logic [1:0]       r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level, r_pulse, w_rep;
    always_ff @(posedge Clk or negedge reset)
      if (!reset) begin
        r_estado <= ESTABLE_BAJO;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_pulse  <= 1'b0;
      end else begin
        r_pulse <= w_rep;
        unique case (r_estado)
          ESTABLE_BAJO:
            if (r_s2[i]) begin
              r_estado <= VALIDANDO_ALTO;
              r_cnt    <= '0;
            end
          VALIDANDO_ALTO:
            if (!r_s2[i]) r_estado <= ESTABLE_BAJO;
            else if (r_cnt == DB_MAX) begin
              r_estado <= ESTABLE_ALTO;
              r_level  <= 1'b1;
              r_pulse  <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          ESTABLE_ALTO:
            if (!r_s2[i]) begin
              r_estado <= VALIDANDO_BAJO;
              r_cnt    <= '0;
            end
          VALIDANDO_BAJO:
            if (r_s2[i]) r_estado <= ESTABLE_ALTO;
            else if (r_cnt == DB_MAX) begin
              r_estado <= ESTABLE_BAJO;
              r_level  <= 1'b0;
            end else r_cnt <= r_cnt + 1'b1;
        endcase
      end
    assign btn_level[i] = r_level;
    assign btn_pulse[i] = r_pulse;
`ifdef AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] RATE_MAX  = CNT_W'(REPEAT_RATE - 1);
      logic [CNT_W-1:0] r_rcnt;
      logic             r_fase, w_activo;
      // r_fase selects the inter-repeat period once the first repeat has fired
      assign w_activo = r_estado == ESTABLE_ALTO && r_s2[i];
      assign w_rep    = w_activo && r_rcnt == (r_fase ? RATE_MAX : DELAY_MAX);
      always_ff @(posedge Clk or negedge reset)
        if (!reset) begin
          r_rcnt <= '0;
          r_fase <= 1'b0;
        end else if (w_rep) begin
          r_rcnt <= '0;
          r_fase <= 1'b1;
        end else if (w_activo) r_rcnt <= r_rcnt + 1'b1;
        else begin
          r_rcnt <= '0;
          r_fase <= 1'b0;
        end
    end else begin : g_norep
      assign w_rep = 1'b0;
    end
`else
    assign w_rep = 1'b0;
`endif
  end
endmodule

// File: tb/tb_acondicionador_botones.sv
// tb_acondicionador_botones: run-length reference model plus directed and random stimulus.
module tb_acondicionador_botones;
  localparam int N = 5, D = 4, RD = 10, RR = 3;
  localparam logic [4:0] MASK = 5'b00011;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic Clk = 1'b0, reset = 1'b1;
  logic [N-1:0] btn_in = '0, btn_level, btn_pulse;
  int n_cmp = 0, n_err = 0;
  acondicionador_botones #(
    .N_BOTONES(N), .DEBOUNCE_CYCLES(D), .CNT_W(24),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .Clk(Clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: level flips after D+1 consecutive disagreeing samples of the 2-cycle delayed input;
  // hold counts edges spent stably high, repeats at RD, RD+RR, ...
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pul = '0;
  int run [N];
  int hold [N];
  logic x;
  always @(negedge reset) begin
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0;
    for (int c = 0; c < N; c++) begin run[c] = 0; hold[c] = 0; end
  end
  always @(posedge Clk) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0;
      for (int c = 0; c < N; c++) begin run[c] = 0; hold[c] = 0; end
    end else begin
      for (int c = 0; c < N; c++) begin
        x = m_s2[c];
        m_pul[c] = 1'b0;
        if (x == m_lvl[c]) begin
          hold[c] = (m_lvl[c] && run[c] == 0) ? hold[c] + 1 : 0;
          run[c] = 0;
          if (AR && MASK[c] && hold[c] >= RD && (hold[c] - RD) % RR == 0) m_pul[c] = 1'b1;
        end else begin
          hold[c] = 0;
          run[c]++;
          if (run[c] == D + 1) begin
            m_lvl[c] = x;
            run[c] = 0;
            m_pul[c] = x;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end
  always @(negedge Clk) begin
    check("model_level", 32'(btn_level), 32'(m_lvl));
    check("model_pulse", 32'(btn_pulse), 32'(m_pul));
  end
  task automatic medir(input int ch, input logic [31:0] patron, input int len,
                       output int first, output int n, output int caida);
    first = 0; n = 0; caida = 0;
    for (int k = 1; k <= len + 14; k++) begin
      btn_in[ch] = (k <= len) ? patron[k-1] : 1'b0;
      @(posedge Clk); #1;
      if (btn_pulse[ch]) begin n++; if (first == 0) first = k; end
      if (first != 0 && caida == 0 && !btn_level[ch]) caida = k;
    end
  endtask
  int f, n, cd;
  initial begin
    #1 reset = 1'b0; btn_in = '1;
    repeat (3) @(posedge Clk); #1;
    check("rst_level", 32'(btn_level), 0);
    check("rst_pulse", 32'(btn_pulse), 0);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      if (k == 6) check("rel_pulse_e6", 32'(btn_pulse), 0);
      if (k == 7) begin
        check("rel_pulse_e7", 32'(btn_pulse), 32'h1f);
        check("rel_level_e7", 32'(btn_level), 32'h1f);
      end
      if (k == 8) check("rel_pulse_e8", 32'(btn_pulse), 0);
    end
    btn_in = '0;
    repeat (12) @(posedge Clk); #1;
    medir(0, 32'h000F_FFFF, 20, f, n, cd);
    check("clean_first", f, 7);
    check("clean_count", n, AR ? 3 : 1);
    check("clean_fall", cd, 27);
    medir(2, 32'h000F_FFF5, 20, f, n, cd);
    check("bounce_first", f, 11);
    check("bounce_count", n, 1);
    check("bounce_fall", cd, 27);
    medir(4, 32'h0000_0007, 3, f, n, cd);
    check("glitch_count", n, 0);
    check("glitch_level", 32'(btn_level[4]), 0);
    medir(1, 32'h3FFF_FFFF, 30, f, n, cd);
    check("rep1_first", f, 7);
    check("rep1_count", n, AR ? 7 : 1);
    medir(3, 32'h3FFF_FFFF, 30, f, n, cd);
    check("rep3_count", n, 1);
    btn_in[1] = 1'b1;
    repeat (5) @(posedge Clk); #1;
    reset = 1'b0; btn_in[1] = 1'b0;
    repeat (2) @(posedge Clk); #1;
    reset = 1'b1; n = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clk); #1;
      n += int'(btn_pulse[1]);
    end
    check("rstmid_count", n, 0);
    check("rstmid_level", 32'(btn_level[1]), 0);
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, ((k / 500) % 2) ? 39 : 5) == 0) btn_in[c] = ~btn_in[c];
      if ($urandom_range(0, 399) == 0) reset = 1'b0;
      else if (!reset && $urandom_range(0, 1) == 1) reset = 1'b1;
      @(posedge Clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
